// File: rtl/PKG_dla_regmap.sv
// rtl/PKG_dla_regmap.sv - register addresses of the global register block
package PKG_dla_regmap;

    localparam logic [7:0] ADDR_GLB_INTR = 8'h10;

endpackage

// File: rtl/PKG_dla_typedef.sv
// rtl/PKG_dla_typedef.sv - host command opcodes and sequencer state encoding
package PKG_dla_typedef;

    typedef enum logic [1:0] {
        CMD_WRITE = 2'd0,
        CMD_GO    = 2'd1,
        CMD_WAIT  = 2'd2,
        CMD_NOP   = 2'd3
    } host_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_GO    = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CLEAR = 3'd4
    } host_state_e;

endpackage

// File: rtl/dla_regif_host.sv
// rtl/dla_regif_host.sv - host command sequencer; optional WAIT timeout via DLA_REGIF_HOST_TIMEOUT_EN
module dla_regif_host
    import PKG_dla_typedef::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1048576,
    parameter logic [7:0]  ADDR_GLB_INTR  = PKG_dla_regmap::ADDR_GLB_INTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_addr,
    input  logic [31:0] cmd_data,
    output logic        regif_wen,
    output logic [7:0]  regif_addr,
    output logic [31:0] regif_wdata,
    input  logic [31:0] glb_intr_rdata,
    input  logic        interrupt,
    output logic        go_mov_ddr2gb,
    output logic        go_mov_gb2lb,
    output logic        go_comp_conv,
    output logic        go_comp_fc,
    output logic        go_comp_ape,
    output logic        go_comp_reshape,
    input  logic        err_clr,
    output logic        err_cmd,
    output logic        err_timeout,
    output logic        busy
);

    host_state_e state_q, state_d;
    logic [5:0]  mask_q, mask_d;
    logic        wen_q, wen_d;
    logic [7:0]  raddr_q, raddr_d;
    logic [31:0] rwdata_q, rwdata_d;
    logic [5:0]  go_q, go_d;
    logic        err_cmd_q, err_cmd_d;
    logic        busy_q, busy_d;
    logic        err_cmd_set;
    logic        wait_done;
    logic        timeout_hit;

    // all pending interrupt bits named by the mask are set while the pad is high
    assign wait_done = interrupt && ((glb_intr_rdata[5:0] & mask_q) == mask_q);

`ifdef DLA_REGIF_HOST_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        err_to_q, err_to_d;

    assign timeout_hit = (cnt_q == TIMEOUT_CYCLES - 32'd1);

    // wait-cycle counter, restarted on every WAIT entry
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE)
            cnt_d = 32'd0;
        else if (state_q == ST_WAIT)
            cnt_d = cnt_q + 32'd1;
    end

    // sticky timeout error: a new timeout beats a simultaneous clear
    always_comb begin
        err_to_d = err_to_q & ~err_clr;
        if (state_q == ST_WAIT && mask_q != 6'd0 && !wait_done && timeout_hit)
            err_to_d = 1'b1;
    end

    // counter and timeout error flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= 32'd0;
            err_to_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            err_to_q <= err_to_d;
        end
    end

    assign err_timeout = err_to_q;
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    logic unused_rdata;
    assign unused_rdata = ^glb_intr_rdata[31:6];

    // next-state and next-output computation for the command sequencer
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        wen_d       = 1'b0;
        raddr_d     = raddr_q;
        rwdata_d    = rwdata_q;
        go_d        = 6'd0;
        err_cmd_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    mask_d = cmd_data[5:0];
                    case (cmd_op)
                        CMD_WRITE: begin
                            state_d  = ST_WRITE;
                            wen_d    = 1'b1;
                            raddr_d  = cmd_addr;
                            rwdata_d = cmd_data;
                        end
                        CMD_GO: begin
                            state_d = ST_GO;
                            if (cmd_data[2:0] <= 3'd5)
                                go_d = 6'd1 << cmd_data[2:0];
                            else
                                err_cmd_set = 1'b1;
                        end
                        CMD_WAIT: state_d = ST_WAIT;
                        default:  state_d = ST_IDLE;
                    endcase
                end
            end
            ST_WAIT: begin
                if (mask_q == 6'd0) begin
                    state_d = ST_IDLE;
                end else if (wait_done) begin
                    state_d  = ST_CLEAR;
                    wen_d    = 1'b1;
                    raddr_d  = ADDR_GLB_INTR;
                    rwdata_d = {26'd0, glb_intr_rdata[5:0] & ~mask_q};
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        err_cmd_d = err_cmd_set | (err_cmd_q & ~err_clr);
        busy_d    = (state_d != ST_IDLE);
    end

    // state and registered outputs; reset discards any in-flight command
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mask_q    <= 6'd0;
            wen_q     <= 1'b0;
            raddr_q   <= 8'd0;
            rwdata_q  <= 32'd0;
            go_q      <= 6'd0;
            err_cmd_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            wen_q     <= wen_d;
            raddr_q   <= raddr_d;
            rwdata_q  <= rwdata_d;
            go_q      <= go_d;
            err_cmd_q <= err_cmd_d;
            busy_q    <= busy_d;
        end
    end

    assign cmd_ready       = (state_q == ST_IDLE);
    assign regif_wen       = wen_q;
    assign regif_addr      = raddr_q;
    assign regif_wdata     = rwdata_q;
    assign go_mov_ddr2gb   = go_q[0];
    assign go_mov_gb2lb    = go_q[1];
    assign go_comp_conv    = go_q[2];
    assign go_comp_fc      = go_q[3];
    assign go_comp_ape     = go_q[4];
    assign go_comp_reshape = go_q[5];
    assign err_cmd         = err_cmd_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_dla_regif_host.sv
// tb/tb_dla_regif_host.sv - directed table-driven bench for dla_regif_host
module tb_dla_regif_host;

    localparam logic [7:0] GLB = 8'h10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd3;
    logic [7:0]  cmd_addr = 8'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        regif_wen;
    logic [7:0]  regif_addr;
    logic [31:0] regif_wdata;
    logic [31:0] glb_intr_rdata = 32'd0;
    logic        interrupt = 1'b0;
    logic        go_mov_ddr2gb, go_mov_gb2lb, go_comp_conv, go_comp_fc, go_comp_ape, go_comp_reshape;
    logic        err_clr = 1'b0;
    logic        err_cmd, err_timeout, busy;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dla_regif_host #(.TIMEOUT_CYCLES(32'd16), .ADDR_GLB_INTR(GLB)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .regif_wen(regif_wen), .regif_addr(regif_addr), .regif_wdata(regif_wdata),
        .glb_intr_rdata(glb_intr_rdata), .interrupt(interrupt),
        .go_mov_ddr2gb(go_mov_ddr2gb), .go_mov_gb2lb(go_mov_gb2lb),
        .go_comp_conv(go_comp_conv), .go_comp_fc(go_comp_fc),
        .go_comp_ape(go_comp_ape), .go_comp_reshape(go_comp_reshape),
        .err_clr(err_clr), .err_cmd(err_cmd), .err_timeout(err_timeout), .busy(busy)
    );

    function automatic logic [5:0] go_vec();
        return {go_comp_reshape, go_comp_ape, go_comp_fc, go_comp_conv, go_mov_gb2lb, go_mov_ddr2gb};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // present one command for one accept cycle; returns at posedge+1
    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [31:0] d, input logic clr);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        err_clr   = clr;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        err_clr   = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  addr;
        logic [31:0] data;
        logic        clr;
        logic        e_wen;
        logic [7:0]  e_addr;
        logic [31:0] e_wdata;
        logic [5:0]  e_go;
        logic        e_err;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{2'd0, 8'h08, 32'h0000_00F0, 1'b0, 1'b1, 8'h08, 32'h0000_00F0, 6'h00, 1'b0};
        vecs[1] = '{2'd0, 8'hFF, 32'hDEAD_BEEF, 1'b0, 1'b1, 8'hFF, 32'hDEAD_BEEF, 6'h00, 1'b0};
        vecs[2] = '{2'd1, 8'h00, 32'h0000_0000, 1'b0, 1'b0, 8'hFF, 32'hDEAD_BEEF, 6'h01, 1'b0};
        vecs[3] = '{2'd1, 8'h00, 32'h0000_0002, 1'b0, 1'b0, 8'hFF, 32'hDEAD_BEEF, 6'h04, 1'b0};
        vecs[4] = '{2'd1, 8'h00, 32'h0000_0005, 1'b0, 1'b0, 8'hFF, 32'hDEAD_BEEF, 6'h20, 1'b0};
        vecs[5] = '{2'd1, 8'h33, 32'hFFFF_FFF9, 1'b0, 1'b0, 8'hFF, 32'hDEAD_BEEF, 6'h02, 1'b0};
        vecs[6] = '{2'd1, 8'h00, 32'h0000_0007, 1'b0, 1'b0, 8'hFF, 32'hDEAD_BEEF, 6'h00, 1'b1};
        vecs[7] = '{2'd1, 8'h00, 32'h0000_0003, 1'b1, 1'b0, 8'hFF, 32'hDEAD_BEEF, 6'h08, 1'b0};
        vecs[8] = '{2'd1, 8'h00, 32'h0000_0006, 1'b1, 1'b0, 8'hFF, 32'hDEAD_BEEF, 6'h00, 1'b1};
        vecs[9] = '{2'd0, 8'h00, 32'h0000_0000, 1'b0, 1'b1, 8'h00, 32'h0000_0000, 6'h00, 1'b1};

        // reset state
        #2;
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wen", {31'd0, regif_wen}, 32'd0);
        chk("rst_addr", {24'd0, regif_addr}, 32'd0);
        chk("rst_wdata", regif_wdata, 32'd0);
        chk("rst_go", {26'd0, go_vec()}, 32'd0);
        chk("rst_errs", {30'd0, err_cmd, err_timeout}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // WRITE / GO table
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].clr);
            chk($sformatf("v%0d_wen", i), {31'd0, regif_wen}, {31'd0, vecs[i].e_wen});
            chk($sformatf("v%0d_addr", i), {24'd0, regif_addr}, {24'd0, vecs[i].e_addr});
            chk($sformatf("v%0d_wdata", i), regif_wdata, vecs[i].e_wdata);
            chk($sformatf("v%0d_go", i), {26'd0, go_vec()}, {26'd0, vecs[i].e_go});
            chk($sformatf("v%0d_err", i), {31'd0, err_cmd}, {31'd0, vecs[i].e_err});
            chk($sformatf("v%0d_ready", i), {30'd0, cmd_ready, busy}, 32'd1);
            step();
            chk($sformatf("v%0d_idle", i), {30'd0, cmd_ready, busy}, 32'd2);
            chk($sformatf("v%0d_quiet", i), {25'd0, regif_wen, go_vec()}, 32'd0);
            chk($sformatf("v%0d_hold", i), {24'd0, regif_addr}, {24'd0, vecs[i].e_addr});
        end

        // err_clr alone clears the sticky error
        @(negedge clk);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("errclr", {31'd0, err_cmd}, 32'd0);

        // NOP consumed in one cycle
        send(2'd3, 8'h00, 32'h0, 1'b0);
        chk("nop_idle", {30'd0, cmd_ready, busy}, 32'd2);

        // WAIT with empty mask returns next cycle, no write
        send(2'd2, 8'h00, 32'hFFFF_FFC0, 1'b0);
        chk("wait0_busy", {31'd0, busy}, 32'd1);
        step();
        chk("wait0_done", {30'd0, busy, regif_wen}, 32'd0);

        // WAIT mask 04: 10 idle cycles, then interrupt with rdata 05
        send(2'd2, 8'h00, 32'h0000_0004, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("w4_hold%0d", i), {30'd0, busy, regif_wen}, 32'd2);
            step();
        end
        @(negedge clk);
        interrupt = 1'b1;
        glb_intr_rdata = 32'h0000_0005;
        step();
        chk("w4_wen", {31'd0, regif_wen}, 32'd1);
        chk("w4_addr", {24'd0, regif_addr}, {24'd0, GLB});
        chk("w4_wdata", regif_wdata, 32'h0000_0001);
        step();
        chk("w4_end", {30'd0, busy, regif_wen}, 32'd0);

        // partial mask match keeps waiting; bits outside the mask retained
        interrupt = 1'b1;
        glb_intr_rdata = 32'hFFFF_FF04;
        send(2'd2, 8'h00, 32'h0000_0005, 1'b0);
        step();
        step();
        chk("w5_partial", {30'd0, busy, regif_wen}, 32'd2);
        @(negedge clk);
        interrupt = 1'b0;
        glb_intr_rdata = 32'h0000_0037;
        step();
        chk("w5_nointr", {30'd0, busy, regif_wen}, 32'd2);
        @(negedge clk);
        interrupt = 1'b1;
        step();
        chk("w5_wdata", {31'd0, regif_wen, regif_wdata[30:0]}, 32'h8000_0032);
        step();
        interrupt = 1'b0;
        glb_intr_rdata = 32'h0;

        // WAIT mask 01 with no interrupt
        send(2'd2, 8'h00, 32'h0000_0001, 1'b0);
`ifdef DLA_REGIF_HOST_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            if (regif_wen !== 1'b0 || busy !== 1'b1 || err_timeout !== 1'b0)
                chk("to_early", {29'd0, regif_wen, busy, err_timeout}, 32'd2);
            step();
        end
        chk("to_last_wait", {29'd0, regif_wen, busy, err_timeout}, 32'd2);
        step();
        chk("to_fired", {29'd0, regif_wen, busy, err_timeout}, 32'd1);
        step();
        chk("to_sticky", {31'd0, err_timeout}, 32'd1);
        send(2'd2, 8'h00, 32'h0000_0002, 1'b0);
        step();
`else
        for (int i = 0; i < 40; i++) step();
        chk("nto_busy", {29'd0, regif_wen, busy, err_timeout}, 32'd2);
`endif

        // async reset in the middle of WAIT
        chk("prerst_busy", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_out", {22'd0, regif_wen, go_vec(), err_cmd, err_timeout, |regif_addr}, 32'd0);
        chk("rst_mid_wdata", regif_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("post_ready", {31'd0, cmd_ready}, 32'd1);
        send(2'd3, 8'h00, 32'h0, 1'b0);
        chk("post_nop", {30'd0, cmd_ready, busy}, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
